// File: rtl/exu_alu_md.sv
// rtl/exu_alu_md.sv - execute stage: 1-cycle integer ALU plus iterative radix-2 multiply/divide
module exu_alu_md #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic             in_use_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int SH_W = $clog2(XLEN);
    localparam int CW   = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag;
    logic [CNT_W-1:0]  r_retire;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_negr;
    logic              r_div0;

    logic [XLEN-1:0]   w_b;
    logic [SH_W-1:0]   w_shamt;
    logic              w_is_md;
    logic              w_accept;
    logic              w_retire;
    logic [XLEN-1:0]   w_alu;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shr;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_md_res;

    assign w_b      = in_use_imm ? in_imm : in_rs2;
    assign w_shamt  = w_b[SH_W-1:0];
    assign w_is_md  = (in_op[4:3] == 2'b10);
    assign in_ready = !flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_retire = !flush && (r_state == S_DONE) && out_ready;

    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_BUSY);
    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign retire_cnt = r_retire;

    always_comb begin
        w_alu = '0;
        case (in_op)
            5'd0:    w_alu = in_rs1 + w_b;
            5'd1:    w_alu = in_rs1 - w_b;
            5'd2:    w_alu = in_rs1 << w_shamt;
            5'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(w_b))};
            5'd4:    w_alu = {{(XLEN-1){1'b0}}, (in_rs1 < w_b)};
            5'd5:    w_alu = in_rs1 ^ w_b;
            5'd6:    w_alu = in_rs1 >> w_shamt;
            5'd7:    w_alu = $signed(in_rs1) >>> w_shamt;
            5'd8:    w_alu = in_rs1 | w_b;
            5'd9:    w_alu = in_rs1 & w_b;
            5'd10:   w_alu = w_b;
            default: w_alu = '0;
        endcase
    end

    // Both multiply and divide iterate on magnitudes; the sign is applied once at the end.
    assign w_a_neg = (in_op inside {5'd17, 5'd18, 5'd20, 5'd22}) && in_rs1[XLEN-1];
    assign w_b_neg = (in_op inside {5'd17, 5'd20, 5'd22}) && w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -in_rs1 : in_rs1;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_shr  = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff = w_shr - {1'b0, r_opb};

    always_comb begin
        w_acc_nx = {w_sum, r_acc[XLEN-1:1]};
        if (r_op[2]) begin
            if (w_diff[XLEN])
                w_acc_nx = {w_shr[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_nx = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    assign w_prod = r_neg ? -w_acc_nx : w_acc_nx;
    assign w_quo  = w_acc_nx[XLEN-1:0];
    assign w_rem  = w_acc_nx[2*XLEN-1:XLEN];

    // Divide-by-zero quotient is forced; its remainder (|a| re-signed) already equals a.
    always_comb begin
        w_md_res = '0;
        case (r_op)
            3'd0:       w_md_res = w_prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       w_md_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: w_md_res = r_div0 ? {XLEN{1'b1}} : (r_neg ? -w_quo : w_quo);
            default:    w_md_res = r_negr ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_tag    <= '0;
            r_retire <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_negr   <= 1'b0;
            r_div0   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            if (w_retire)
                r_retire <= r_retire + CNT_W'(1);
            case (r_state)
                S_BUSY: begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_md_res;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_tag <= in_tag;
                        if (w_is_md) begin
                            r_state <= S_BUSY;
                            r_cnt   <= CW'(XLEN);
                            r_op    <= in_op[2:0];
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_negr  <= w_a_neg;
                            r_div0  <= (w_b == '0);
                            r_opb   <= in_op[2] ? w_b_mag : w_a_mag;
                            r_acc   <= {{XLEN{1'b0}}, in_op[2] ? w_a_mag : w_b_mag};
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_alu;
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exu_alu_md.sv
// tb/tb_exu_alu_md.sv - vector table, random ops against a reference model, and handshake corner cases
module tb_exu_alu_md;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic        in_use_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [63:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [63:0] out_tag;
    logic        busy;
    logic [31:0] retire_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_retire = 0;

    exu_alu_md #(.XLEN(32), .TAG_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .busy(busy), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_imm;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp;
        logic [63:0] up;
        logic signed [31:0] t;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        t   = a;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        up  = {32'b0, a} * {32'b0, b};
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return t >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd16: return up[31:0];
            5'd17: begin sp = sa * sb; return sp[63:32]; end
            5'd18: begin sp = sa * longint'({32'b0, b}); return sp[63:32]; end
            5'd19: return up[63:32];
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_imm, input logic [63:0] tag);
        in_op      = op;
        in_rs1     = a;
        in_use_imm = use_imm;
        in_rs2     = use_imm ? ~b : b;
        in_imm     = use_imm ? b : ~b;
        in_tag     = tag;
    endtask

    // Issue one op from idle with out_ready high; checks latency, result, tag and the retire.
    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_imm, input logic [31:0] exp);
        logic [63:0] tag;
        int k;
        int lat;
        tag = {$urandom, $urandom};
        lat = (op[4:3] == 2'b10) ? 33 : 1;
        drive(op, a, b, use_imm, tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        chk({nm, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (lat > 1) chk({nm, " busy"}, busy, 1);
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " result"}, out_result, exp);
        chk({nm, " tag"}, out_tag, tag);
        @(posedge clk); #1;
        exp_retire++;
        chk({nm, " retire_cnt"}, retire_cnt, exp_retire);
        chk({nm, " out_valid low"}, out_valid, 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t b2b[4];
        logic [4:0] ops[20];
        logic [31:0] specials[6];
        logic [31:0] hold_res;
        logic [63:0] hold_tag;
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        logic        seen;

        tbl.push_back('{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000});
        tbl.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE});
        tbl.push_back('{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001});
        tbl.push_back('{5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD});
        tbl.push_back('{5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF});
        tbl.push_back('{5'd21, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF});
        tbl.push_back('{5'd22, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0005});
        tbl.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000});
        tbl.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
        tbl.push_back('{5'd20, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF});
        tbl.push_back('{5'd22, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'hFFFF_FFF9});
        tbl.push_back('{5'd7,  32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000});
        tbl.push_back('{5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001});
        tbl.push_back('{5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000});
        tbl.push_back('{5'd2,  32'h0000_0001, 32'h0000_0021, 1'b1, 32'h0000_0002});
        tbl.push_back('{5'd12, 32'h1234_5678, 32'h0000_0001, 1'b0, 32'h0000_0000});
        tbl.push_back('{5'd17, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000});
        tbl.push_back('{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF});
        tbl.push_back('{5'd10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D});

        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd27};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 1'b0, 64'h0);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset retire_cnt", retire_cnt, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_tag", out_tag, 0);
        chk("reset in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].use_imm, tbl[i].exp);

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(19, 0)];
            ra  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
            rb  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
            if ($urandom_range(3, 0) == 0) rb = $urandom_range(15, 0);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'($urandom_range(1, 0)), model(rop, ra, rb));
        end

        // Back-to-back ALU ops with both handshakes held high.
        for (int i = 0; i < 4; i++) begin
            b2b[i].op = 5'($urandom_range(9, 0));
            b2b[i].a  = $urandom;
            b2b[i].b  = $urandom;
            b2b[i].exp = model(b2b[i].op, b2b[i].a, b2b[i].b);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(b2b[0].op, b2b[0].a, b2b[0].b, 1'b0, 64'd100);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b%0d in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d out_valid", i), out_valid, 1);
            chk($sformatf("b2b%0d result", i), out_result, b2b[i].exp);
            chk($sformatf("b2b%0d tag", i), out_tag, 64'(100 + i));
            if (i < 3) drive(b2b[i+1].op, b2b[i+1].a, b2b[i+1].b, 1'b0, 64'(101 + i));
            else in_valid = 1'b0;
            if (i > 0) exp_retire++;
        end
        @(posedge clk); #1;
        exp_retire++;
        chk("b2b retire_cnt", retire_cnt, exp_retire);

        // Back-pressure on a SUB result.
        out_ready = 1'b0;
        drive(5'd1, 32'd10, 32'd3, 1'b0, 64'hABCD_0001);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(5'd0, 32'h55, 32'h66, 1'b0, 64'h9999);
        hold_res = out_result;
        hold_tag = out_tag;
        chk("bp result", hold_res, 32'd7);
        chk("bp tag", hold_tag, 64'hABCD_0001);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d out_valid", i), out_valid, 1);
            chk($sformatf("bp%0d in_ready", i), in_ready, 0);
            chk($sformatf("bp%0d result", i), out_result, hold_res);
            chk($sformatf("bp%0d tag", i), out_tag, hold_tag);
            chk($sformatf("bp%0d retire_cnt", i), retire_cnt, exp_retire);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_retire++;
        chk("bp release retire_cnt", retire_cnt, exp_retire);
        chk("bp release out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bp single retire", retire_cnt, exp_retire);

        // Flush in the tenth cycle of a DIVU.
        drive(5'd21, 32'd1000, 32'd7, 1'b0, 64'hF1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        chk("flush in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush out_valid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush no late result", seen, 0);
        chk("flush retire_cnt", retire_cnt, exp_retire);
        run_op("after flush", 5'd21, 32'd1000, 32'd7, 1'b0, 32'd142);

        // Asynchronous reset mid-iteration.
        drive(5'd16, 32'h1234, 32'h5678, 1'b0, 64'hFEED);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_retire = 0;
        chk("arst busy", busy, 0);
        chk("arst out_valid", out_valid, 0);
        chk("arst retire_cnt", retire_cnt, 0);
        chk("arst out_result", out_result, 0);
        chk("arst out_tag", out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("after reset", 5'd16, 32'h1234, 32'h5678, 1'b0, 32'h0626_0060);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
